// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin share of one UARTtx serializer among N_REQ byte producers.
// Latency : request seen in ARB at edge t -> tx_send and req_ready high in cycle t+1; frame gap 2 cycles.
// Backpr. : requesters hold req_valid until their req_ready pulse; no grant while tx_idle is low.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   req_valid/req_data   per-requester pending flag and byte (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready            one-hot 1-cycle accept pulse, coincident with tx_send
//   tx_data/tx_send      byte and start pulse to UARTtx; tx_data stable until back in ARB
//   tx_idle              UARTtx idle indication
//   grant_id             index of current/last winner
//   busy                 high whenever the FSM is not in ARB
//   timeout              1-cycle pulse when UARTtx never left idle after tx_send
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_send,
  input  logic                          tx_idle,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy,
  output logic                          timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(START_TIMEOUT);

  localparam logic [1:0] ST_ARB        = 2'd0;
  localparam logic [1:0] ST_ISSUE      = 2'd1;
  localparam logic [1:0] ST_WAIT_START = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  wait_cnt;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] ptr_next;

  // (a + b) mod N_REQ for b in [0, N_REQ-1]; works for non-power-of-two N_REQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  // Scan from the farthest offset back to the pointer so the candidate closest
  // to the pointer (highest priority) is the last one written and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = wrap_add(ptr, i);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_next = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_ARB;
      ptr       <= '0;
      wait_cnt  <= '0;
      req_ready <= '0;
      tx_send   <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // Pulse outputs default low; set only on the edge that enters ISSUE / times out.
      req_ready <= '0;
      tx_send   <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        ST_ARB: begin
          if (tx_idle && win_found) begin
            tx_data   <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            grant_id  <= win_idx;
            ptr       <= ptr_next;
            tx_send   <= 1'b1;
            req_ready <= N_REQ'(1) << win_idx;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (!tx_idle) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt == CW'(START_TIMEOUT - 1)) begin
            // UARTtx never started: drop the byte rather than retry it.
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_ARB;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (tx_idle) begin
            busy  <= 1'b0;
            state <= ST_ARB;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_ARB;
        end
      endcase
    end
  end

endmodule
